// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hold/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN     = 2'd0,
        CTRL_DRAIN   = 2'd1,
        CTRL_GRANT   = 2'd2,
        CTRL_RELEASE = 2'd3
    } ctrl_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect/bus-request inputs and pipeline hold/flush controls of pipe_ctrl.
interface pipe_ctrl_if #(parameter int ADDR_W = 32);

    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              load_use_i;
    logic              muldiv_busy_i;
    logic              bus_req_i;
    logic              bus_gnt_o;
    logic              hold_pc_o;
    logic              hold_if_id_o;
    logic              hold_id_ex_o;
    logic              flush_if_id_o;
    logic              flush_id_ex_o;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;

    modport master (
        output jump_flag_i, jump_addr_i, load_use_i, muldiv_busy_i, bus_req_i,
        input  bus_gnt_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, jump_flag_o, jump_addr_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, load_use_i, muldiv_busy_i, bus_req_i,
        output bus_gnt_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, jump_flag_o, jump_addr_o
    );

endinterface

// File: rtl/pipe_ctrl_bus_hold_timer.sv
// Watchdog limiting how long the external master may keep the bus.
module bus_hold_timer #(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] TC = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Terminal count is reached on the MAX_HOLD-th grant cycle, so it never wraps.
    assign expired = en && (r_cnt == TC);

endmodule

// File: rtl/pipe_ctrl.sv
// Per-cycle stall/flush/redirect decode for the five-stage core plus bus-ownership FSM.
//
//   state   | meaning
//   RUN     | normal operation, no bus request pending
//   DRAIN   | bus requested, waiting for mul/div to finish before freezing
//   GRANT   | pipeline frozen, external master owns the bus
//   RELEASE | one guaranteed cycle of core progress, bus_req_i ignored
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int BUS_MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   ctrl_if
);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next;
    logic              r_gnt;
    logic              w_in_grant;
    logic              w_expired;
    logic              w_freeze;
    logic              w_hold_pc;
    logic              w_hold_if_id;
    logic              w_hold_id_ex;
    logic              w_flush_if_id;
    logic              w_flush_id_ex;
    logic              w_jump;
    logic [ADDR_W-1:0] w_jump_addr;

    assign w_in_grant = (r_state == CTRL_GRANT);

    bus_hold_timer #(.MAX_HOLD(BUS_MAX_HOLD)) u_bus_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!w_in_grant),
        .en      (w_in_grant),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CTRL_RUN;
            r_gnt   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt   <= (w_next == CTRL_GRANT);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CTRL_RUN: begin
                if (ctrl_if.bus_req_i) w_next = CTRL_DRAIN;
            end
            CTRL_DRAIN: begin
                if (!ctrl_if.bus_req_i)          w_next = CTRL_RUN;
                else if (!ctrl_if.muldiv_busy_i) w_next = CTRL_GRANT;
            end
            CTRL_GRANT: begin
                if (!ctrl_if.bus_req_i || w_expired) w_next = CTRL_RELEASE;
            end
            CTRL_RELEASE: w_next = CTRL_RUN;
            default:      w_next = CTRL_RUN;
        endcase
    end

    // The DRAIN->GRANT cycle already freezes like GRANT so a jump in EX is kept, not half-applied.
    assign w_freeze = w_in_grant ||
                      ((r_state == CTRL_DRAIN) && ctrl_if.bus_req_i && !ctrl_if.muldiv_busy_i);

    always_comb begin
        w_hold_pc     = 1'b0;
        w_hold_if_id  = 1'b0;
        w_hold_id_ex  = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_jump        = 1'b0;
        if (rst) begin
            w_hold_pc     = 1'b1;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (w_freeze || ctrl_if.muldiv_busy_i) begin
            w_hold_pc    = 1'b1;
            w_hold_if_id = 1'b1;
            w_hold_id_ex = 1'b1;
        end else if (ctrl_if.jump_flag_i) begin
            w_jump        = 1'b1;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (ctrl_if.load_use_i) begin
            w_hold_pc     = 1'b1;
            w_hold_if_id  = 1'b1;
            w_flush_id_ex = 1'b1;
        end
    end

    assign w_jump_addr = w_jump ? ctrl_if.jump_addr_i : '0;

    assign ctrl_if.bus_gnt_o     = r_gnt;
    assign ctrl_if.hold_pc_o     = w_hold_pc;
    assign ctrl_if.hold_if_id_o  = w_hold_if_id;
    assign ctrl_if.hold_id_ex_o  = w_hold_id_ex;
    assign ctrl_if.flush_if_id_o = w_flush_if_id;
    assign ctrl_if.flush_id_ex_o = w_flush_id_ex;
    assign ctrl_if.jump_flag_o   = w_jump;
    assign ctrl_if.jump_addr_o   = w_jump_addr;

    a_no_jump_while_busy: assert property (@(posedge clk) disable iff (rst)
        !(ctrl_if.muldiv_busy_i && ctrl_if.jump_flag_i && !w_in_grant));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog (BUS_MAX_HOLD=4).
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.ADDR_W(32)) pif ();

    pipe_ctrl #(.ADDR_W(32), .BUS_MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {gnt, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_flag}
    function automatic logic [6:0] outs();
        return {pif.bus_gnt_o, pif.hold_pc_o, pif.hold_if_id_o, pif.hold_id_ex_o,
                pif.flush_if_id_o, pif.flush_id_ex_o, pif.jump_flag_o};
    endfunction

    task automatic drive(input logic jf, input logic [31:0] ja, input logic lu,
                         input logic mb, input logic br);
        @(negedge clk);
        pif.jump_flag_i   = jf;
        pif.jump_addr_i   = ja;
        pif.load_use_i    = lu;
        pif.muldiv_busy_i = mb;
        pif.bus_req_i     = br;
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] o;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        o = outs();
        checks++;
        if (o !== 7'b0_100_110) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b", o, 7'b0_100_110);
        end
        checks++;
        if (pif.jump_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_jump_addr: got %h expected %h", pif.jump_addr_o, 32'h0);
        end
        rst = 1'b0;
        #1;
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", o, 7'b0);
        end
    endtask

    task automatic test_jump();
        logic [6:0] o;
        drive(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0_000_111) begin
            errors++;
            $display("FAIL jump_outs: got %b expected %b", o, 7'b0_000_111);
        end
        checks++;
        if (pif.jump_addr_o !== 32'h0000_0100) begin
            errors++;
            $display("FAIL jump_addr: got %h expected %h", pif.jump_addr_o, 32'h0000_0100);
        end
        drive(1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pif.jump_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL jump_addr_idle: got %h expected %h", pif.jump_addr_o, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] o;
        drive(1'b1, 32'hDEAD_BEEC, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0_000_111 || pif.jump_addr_o !== 32'hDEAD_BEEC) begin
            errors++;
            $display("FAIL b2b_jump: got %b/%h expected %b/%h", o, pif.jump_addr_o,
                     7'b0_000_111, 32'hDEAD_BEEC);
        end
        drive(1'b0, 32'hDEAD_BEEC, 1'b1, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0_110_010) begin
            errors++;
            $display("FAIL b2b_load_use: got %b expected %b", o, 7'b0_110_010);
        end
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0_000_111 || pif.jump_addr_o !== 32'h0000_0040) begin
            errors++;
            $display("FAIL b2b_jump2: got %b/%h expected %b/%h", o, pif.jump_addr_o,
                     7'b0_000_111, 32'h0000_0040);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] o;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0_110_010) begin
            errors++;
            $display("FAIL load_use_bubble: got %b expected %b", o, 7'b0_110_010);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL load_use_after: got %b expected %b", o, 7'b0);
        end
    endtask

    task automatic test_muldiv();
        logic [6:0] o;
        for (int i = 0; i < 33; i++) begin
            drive(1'b0, 32'h0, (i == 7), 1'b1, 1'b0);
            o = outs();
            checks++;
            if (o !== 7'b0_111_000) begin
                errors++;
                $display("FAIL muldiv_hold[%0d]: got %b expected %b", i, o, 7'b0_111_000);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL muldiv_done: got %b expected %b", o, 7'b0);
        end
    endtask

    task automatic test_drain_grant();
        logic [6:0] o;
        // RUN cycle plus four DRAIN cycles with mul/div still busy
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            o = outs();
            checks++;
            if (o !== 7'b0_111_000) begin
                errors++;
                $display("FAIL drain_busy[%0d]: got %b expected %b", i, o, 7'b0_111_000);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        o = outs();
        checks++;
        if (o !== 7'b0_111_000) begin
            errors++;
            $display("FAIL drain_freeze: got %b expected %b", o, 7'b0_111_000);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        o = outs();
        checks++;
        if (o !== 7'b1_111_000) begin
            errors++;
            $display("FAIL grant_first: got %b expected %b", o, 7'b1_111_000);
        end
        drive(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1);
        o = outs();
        checks++;
        if (o !== 7'b1_111_000 || pif.jump_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL grant_jump_blocked: got %b/%h expected %b/%h", o, pif.jump_addr_o,
                     7'b1_111_000, 32'h0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b1_111_000) begin
            errors++;
            $display("FAIL grant_req_drop: got %b expected %b", o, 7'b1_111_000);
        end
        // RELEASE: request ignored, core runs normally
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        o = outs();
        checks++;
        if (o !== 7'b0_110_010) begin
            errors++;
            $display("FAIL release_runs: got %b expected %b", o, 7'b0_110_010);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL release_to_run: got %b expected %b", o, 7'b0);
        end
        // DRAIN with request dropped: back to RUN, never granted
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL drain_abort: got %b expected %b", o, 7'b0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL drain_abort_no_gnt: got %b expected %b", o, 7'b0);
        end
    endtask

    task automatic test_watchdog();
        logic [15:0] exp_gnt;
        logic [15:0] exp_hold;
        logic [6:0]  o;
        exp_gnt  = 16'b0011_1100_0111_1000;
        exp_hold = 16'b0111_1100_1111_1001;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            o = outs();
            checks++;
            if (o[6] !== exp_gnt[15-i] || o[5] !== exp_hold[15-i]) begin
                errors++;
                $display("FAIL watchdog[%0d]: got gnt=%b hold=%b expected gnt=%b hold=%b",
                         i, o[6], o[5], exp_gnt[15-i], exp_hold[15-i]);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b1_111_000) begin
            errors++;
            $display("FAIL watchdog_end_grant: got %b expected %b", o, 7'b1_111_000);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL watchdog_idle: got %b expected %b", o, 7'b0);
        end
    endtask

    task automatic test_reset_in_grant();
        logic [6:0] o;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (pif.bus_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_grant_reached: got %b expected %b", pif.bus_gnt_o, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        o = outs();
        checks++;
        if (o !== 7'b0_100_110) begin
            errors++;
            $display("FAIL rst_in_grant: got %b expected %b", o, 7'b0_100_110);
        end
        @(negedge clk);
        pif.bus_req_i = 1'b0;
        rst = 1'b0;
        #1;
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL rst_release_run: got %b expected %b", o, 7'b0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        o = outs();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL rst_release_settled: got %b expected %b", o, 7'b0);
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b1;
        pif.jump_flag_i   = 1'b0;
        pif.jump_addr_i   = 32'h0;
        pif.load_use_i    = 1'b0;
        pif.muldiv_busy_i = 1'b0;
        pif.bus_req_i     = 1'b0;
        test_reset();
        test_jump();
        test_load_use();
        test_back_to_back();
        test_muldiv();
        test_drain_grant();
        test_watchdog();
        test_reset_in_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hold/flush controller for the five-stage core: it owns the stall and flush inputs of the PC register, the IF/ID register and the ID/EX register. It decides one outcome per cycle from:
- branch/jump redirects from EX;
- load-use hazards from ID;
- the multi-cycle mul/div unit;
- an external bus master (debug/DMA) requesting the instruction/data bus.

The bus-ownership part is a small FSM with a watchdog, so the core is never starved indefinitely.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- BUS_MAX_HOLD, 16, max consecutive cycles the external master may hold the bus (>=2)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- jump_flag_i  in  1  EX requests redirect this cycle
- jump_addr_i  in  ADDR_W  redirect target
- load_use_i  in  1  ID instruction consumes result of load currently in EX
- muldiv_busy_i  in  1  mul/div unit occupying EX, result not ready
- bus_req_i  in  1  external master requests bus, level, held until done
- bus_gnt_o  out  1  bus granted to external master (registered)
- hold_pc_o  out  1  PC keeps its value
- hold_if_id_o  out  1  IF/ID keeps its value
- hold_id_ex_o  out  1  ID/EX keeps its value
- flush_if_id_o  out  1  IF/ID loads NOP, address 0
- flush_id_ex_o  out  1  ID/EX loads NOP
- jump_flag_o  out  1  PC loads jump_addr_o
- jump_addr_o  out  ADDR_W  passthrough of jump_addr_i, 0 when jump_flag_o=0

## Operation
States: RUN, DRAIN, GRANT, RELEASE.
- RUN -> DRAIN: bus_req_i=1.
- DRAIN -> GRANT: muldiv_busy_i=0. The pipeline is never frozen mid-divide for a bus grant.
- GRANT -> RELEASE: bus_req_i=0, or watchdog count reaches BUS_MAX_HOLD-1.
- RELEASE -> RUN: unconditional, 1 cycle. During RELEASE the core runs normally and bus_req_i is ignored.

Outputs by state:
- GRANT: bus_gnt_o=1; hold_pc/if_id/id_ex=1; no flush; jump_flag_o=0. A pending jump_flag_i stays in frozen EX and is applied after GRANT.
- RUN, DRAIN, RELEASE, checked in this priority:
  1. muldiv_busy_i=1: hold_pc, hold_if_id, hold_id_ex=1; jump_flag_o=0. A simultaneous jump_flag_i is illegal (assertion fires).
  2. jump_flag_i=1: jump_flag_o=1, flush_if_id=1, flush_id_ex=1; holds=0; load_use_i is ignored.
  3. load_use_i=1: hold_pc=1, hold_if_id=1, flush_id_ex=1 (bubble).
  4. Otherwise all controls are 0.
- DRAIN additionally holds pc, if_id and id_ex whenever muldiv is not busy (the transition cycle to GRANT). The effect is that hold starts in the same cycle as the grant.

Watchdog:
- Counter width $clog2(BUS_MAX_HOLD).
- Clears on entry to GRANT; increments each GRANT cycle; holds 0 outside GRANT.

## Timing
- Hold/flush/jump outputs are combinational from inputs and state, with zero latency. They act at the next clk edge of the pipeline registers.
- bus_gnt_o is registered. It rises the cycle after DRAIN sees muldiv_busy_i=0 and falls on the edge that enters RELEASE.
- With no muldiv busy, bus_req_i rising at edge N gives grant at edge N+2 (RUN->DRAIN, DRAIN->GRANT).
- While rst=1, asynchronously:
  - state=RUN, counter=0, bus_gnt_o=0;
  - hold_pc_o=1, flush_if_id_o=1, flush_id_ex_o=1;
  - all other outputs 0.
- rst asserted in GRANT drops bus_gnt_o immediately, without passing through RELEASE.
- bus_req_i dropping in DRAIN: return to RUN next edge, with no grant.
- Watchdog expiry with bus_req_i still high: RELEASE for 1 cycle, then RUN, then DRAIN again (re-arbitration). The minimum guaranteed core progress is 1 cycle per BUS_MAX_HOLD+3 cycles.

## Structure
- State encodings (`CTRL_RUN`, `CTRL_DRAIN`, `CTRL_GRANT`, `CTRL_RELEASE`, 2 bits) go in `defines.v` alongside `INST_NOP`.
- One sub-module, `bus_hold_timer`, owns the watchdog counter. Inputs: clk, rst, clr, en. Output: expired.
- The FSM and the priority decode stay in `pipe_ctrl`.
- Pipeline registers consume hold/flush directly. Flush has priority over hold in the registers.

## Test plan
- Reset: rst=1 mid-GRANT -> bus_gnt_o=0 and hold_pc_o=1 in the same cycle. After release: RUN, all flush=0.
- Jump: jump_flag_i=1, jump_addr_i=0x0000_0100, load_use_i=1 -> jump_flag_o=1, jump_addr_o=0x100, both flushes=1, hold_pc_o=0.
- Load-use: load_use_i=1 for 1 cycle -> hold_pc=1, hold_if_id=1, flush_id_ex=1 for exactly that cycle.
- Muldiv: muldiv_busy_i=1 for 33 cycles -> all holds=1 for 33 cycles, no flush. jump_flag_i injected during busy -> assertion fires, jump_flag_o=0.
- Bus grant with drain: bus_req_i=1 while muldiv_busy_i=1 for 5 more cycles -> bus_gnt_o=0 until busy falls, then 1 on the next edge. Holds=1 throughout GRANT. bus_req_i=0 -> 1 RELEASE cycle with holds=0.
- Watchdog: BUS_MAX_HOLD=4, bus_req_i held high -> pattern repeats: gnt=1 for 4 cycles, then 0 for 3 cycles (RELEASE, RUN, DRAIN).
